atm_controller: RTL and testbench

Parametrised successor to the single-session cashier controller. Handles one card session at a time:
- collects a PIN_DIGITS-digit PIN one digit per strobe and compares it to the stored PIN;
- counts failed attempts up to MAX_TRIES, locks out on the last failure, and supports an admin unlock;
- times out idle sessions;
- performs a deposit or a withdrawal, with registered single-cycle result pulses and a held resulting balance.

It sits between the keypad/card front end and the account-balance store.

---
 rtl/atm_pkg.sv | 17 +
 rtl/atm_pin_capture.sv | 43 ++++
 rtl/atm_controller.sv | 190 +++++++++++++++++++
 tb/tb_atm_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM session controller.
package atm_pkg;

  // Session states, one-hot encoded.
  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_PIN      = 5'b00010,
    ST_CHECK    = 5'b00100,
    ST_WAIT_AMT = 5'b01000,
    ST_LOCKED   = 5'b10000
  } atm_state_e;

  // Transaction type encoding carried on tipo_trans.
  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

endpackage : atm_pkg

// File: rtl/atm_pin_capture.sv
// Collects PIN digits one per strobe, first digit into the least significant slot.
// full_o is high in the cycle whose strobe writes the last slot, so the controller
// can move to its compare state on that same edge.
module atm_pin_capture
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear_i,
  input  logic                          strobe_i,
  input  logic [DIGIT_W-1:0]            digit_i,
  output logic [PIN_DIGITS*DIGIT_W-1:0] pin_o,
  output logic                          full_o
);

  localparam int IDX_W = (PIN_DIGITS > 1) ? $clog2(PIN_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIN_DIGITS - 1);

  logic [IDX_W-1:0]              index_q;
  logic [PIN_DIGITS*DIGIT_W-1:0] pin_q;

  assign full_o = strobe_i && !clear_i && (index_q == LAST_IDX);
  assign pin_o  = pin_q;

  // Clearing wipes both the index and the stored digits so no stale digit survives.
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      index_q <= '0;
      pin_q   <= '0;
    end else if (strobe_i) begin
      for (int i = 0; i < PIN_DIGITS; i++) begin
        if (index_q == IDX_W'(i)) begin
          pin_q[i*DIGIT_W +: DIGIT_W] <= digit_i;
        end
      end
      index_q <= (index_q == LAST_IDX) ? '0 : index_q + IDX_W'(1);
    end
  end

endmodule : atm_pin_capture

// File: rtl/atm_controller.sv
// Single-session ATM controller: PIN entry and check, attempt counting with
// lockout and admin unlock, idle timeout, and one deposit or withdrawal per session.
module atm_controller
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int BAL_W       = 64,
  parameter int AMT_W       = 32,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tarjeta_recibida,
  input  logic                          tipo_trans,
  input  logic                          digito_stb,
  input  logic [DIGIT_W-1:0]            digito,
  input  logic [PIN_DIGITS*DIGIT_W-1:0] pin,
  input  logic [BAL_W-1:0]              balance_inicial,
  input  logic [AMT_W-1:0]              monto,
  input  logic                          monto_stb,
  input  logic                          desbloqueo,
  output logic [BAL_W-1:0]              balance_out,
  output logic                          balance_actualizado,
  output logic                          entregar_dinero,
  output logic                          pin_incorrecto,
  output logic                          advertencia,
  output logic                          bloqueo,
  output logic                          fondos_insuficientes,
  output logic                          tiempo_agotado
);

  localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int ATT_W   = $clog2(MAX_TRIES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  atm_state_e         state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [ATT_W-1:0]   attempts_q;
  logic [ATT_W-1:0]   attempts_d;

  logic                          pinStrobe;
  logic                          pinClear;
  logic                          pinFull;
  logic                          pinMatch;
  logic [PIN_DIGITS*DIGIT_W-1:0] capturedPin;

  logic [BAL_W-1:0] montoExt;
  logic [BAL_W:0]   depositSum;
  logic [BAL_W-1:0] depositSat;
  logic [BAL_W-1:0] withdrawRes;
  logic             fundsOk;

  // Digits are only taken in PIN with the card present; the register is held
  // clear in every other state so each entry into PIN starts at slot 0.
  assign pinStrobe = (state_q == ST_PIN) && tarjeta_recibida && digito_stb;
  assign pinClear  = (state_q != ST_PIN);

  atm_pin_capture #(
    .PIN_DIGITS (PIN_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_pin_capture (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (pinClear),
    .strobe_i (pinStrobe),
    .digit_i  (digito),
    .pin_o    (capturedPin),
    .full_o   (pinFull)
  );

  assign pinMatch   = (capturedPin == pin);
  assign attempts_d = attempts_q + ATT_W'(1);

  assign montoExt    = BAL_W'(monto);
  assign depositSum  = {1'b0, balance_inicial} + {1'b0, montoExt};
  assign depositSat  = depositSum[BAL_W] ? {BAL_W{1'b1}} : depositSum[BAL_W-1:0];
  assign fundsOk     = (montoExt <= balance_inicial);
  assign withdrawRes = balance_inicial - montoExt;

  // Session state machine with registered pulse and level outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q              <= ST_IDLE;
      timer_q              <= '0;
      attempts_q           <= '0;
      balance_out          <= '0;
      balance_actualizado  <= 1'b0;
      entregar_dinero      <= 1'b0;
      pin_incorrecto       <= 1'b0;
      advertencia          <= 1'b0;
      bloqueo              <= 1'b0;
      fondos_insuficientes <= 1'b0;
      tiempo_agotado       <= 1'b0;
    end else begin
      balance_actualizado  <= 1'b0;
      entregar_dinero      <= 1'b0;
      pin_incorrecto       <= 1'b0;
      fondos_insuficientes <= 1'b0;
      tiempo_agotado       <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (tarjeta_recibida) begin
            state_q <= ST_PIN;
          end
        end

        ST_PIN: begin
          if (!tarjeta_recibida) begin
            state_q <= ST_IDLE;
          end else if (pinStrobe) begin
            timer_q <= '0;
            if (pinFull) begin
              state_q <= ST_CHECK;
            end
          end else if (timer_q == TIMER_LAST) begin
            tiempo_agotado <= 1'b1;
            state_q        <= ST_IDLE;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        ST_CHECK: begin
          timer_q <= '0;
          if (pinMatch) begin
            attempts_q  <= '0;
            advertencia <= 1'b0;
            state_q     <= ST_WAIT_AMT;
          end else begin
            pin_incorrecto <= 1'b1;
            if (attempts_d == ATT_W'(MAX_TRIES)) begin
              attempts_q  <= '0;
              advertencia <= 1'b0;
              bloqueo     <= 1'b1;
              state_q     <= ST_LOCKED;
            end else begin
              attempts_q <= attempts_d;
              if (attempts_d == ATT_W'(MAX_TRIES - 1)) begin
                advertencia <= 1'b1;
              end
              state_q <= ST_PIN;
            end
          end
        end

        ST_WAIT_AMT: begin
          if (!tarjeta_recibida) begin
            state_q <= ST_IDLE;
          end else if (monto_stb) begin
            timer_q <= '0;
            state_q <= ST_IDLE;
            if (tipo_trans == TIPO_RETIRO) begin
              if (fundsOk) begin
                balance_out         <= withdrawRes;
                balance_actualizado <= 1'b1;
                entregar_dinero     <= 1'b1;
              end else begin
                fondos_insuficientes <= 1'b1;
              end
            end else begin
              balance_out         <= depositSat;
              balance_actualizado <= 1'b1;
            end
          end else if (timer_q == TIMER_LAST) begin
            tiempo_agotado <= 1'b1;
            state_q        <= ST_IDLE;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        ST_LOCKED: begin
          if (desbloqueo) begin
            bloqueo <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : atm_controller

// File: tb/tb_atm_controller.sv
// Directed bench for atm_controller with hand-computed expected values.
module tb_atm_controller;
  import atm_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        tarjeta_recibida;
  logic        tipo_trans;
  logic        digito_stb;
  logic [3:0]  digito;
  logic [15:0] pin;
  logic [63:0] balance_inicial;
  logic [31:0] monto;
  logic        monto_stb;
  logic        desbloqueo;
  logic [63:0] balance_out;
  logic        balance_actualizado;
  logic        entregar_dinero;
  logic        pin_incorrecto;
  logic        advertencia;
  logic        bloqueo;
  logic        fondos_insuficientes;
  logic        tiempo_agotado;

  int vectorsApplied = 0;
  int miscompares    = 0;

  // Flag order: {balance_actualizado, entregar_dinero, pin_incorrecto,
  //              advertencia, bloqueo, fondos_insuficientes, tiempo_agotado}
  localparam logic [6:0] F_NONE  = 7'b0000000;
  localparam logic [6:0] F_UPD   = 7'b1000000;
  localparam logic [6:0] F_CASH  = 7'b1100000;
  localparam logic [6:0] F_BAD   = 7'b0010000;
  localparam logic [6:0] F_WARN  = 7'b0011000;
  localparam logic [6:0] F_BADW  = 7'b0001000;
  localparam logic [6:0] F_LOCK  = 7'b0010100;
  localparam logic [6:0] F_LOCKD = 7'b0000100;
  localparam logic [6:0] F_NOFND = 7'b0000010;
  localparam logic [6:0] F_TOUT  = 7'b0000001;

  atm_controller dut (
    .clock                (clock),
    .reset                (reset),
    .tarjeta_recibida     (tarjeta_recibida),
    .tipo_trans           (tipo_trans),
    .digito_stb           (digito_stb),
    .digito               (digito),
    .pin                  (pin),
    .balance_inicial      (balance_inicial),
    .monto                (monto),
    .monto_stb            (monto_stb),
    .desbloqueo           (desbloqueo),
    .balance_out          (balance_out),
    .balance_actualizado  (balance_actualizado),
    .entregar_dinero      (entregar_dinero),
    .pin_incorrecto       (pin_incorrecto),
    .advertencia          (advertencia),
    .bloqueo              (bloqueo),
    .fondos_insuficientes (fondos_insuficientes),
    .tiempo_agotado       (tiempo_agotado)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlags(input string tag, input logic [6:0] expected);
    checkOutput(tag, {57'd0, balance_actualizado, entregar_dinero, pin_incorrecto,
                      advertencia, bloqueo, fondos_insuficientes, tiempo_agotado},
                {57'd0, expected});
  endtask

  // Drives one cycle of inputs, then samples just after the rising edge.
  task automatic applyStimulus(input logic card, input logic dStb, input logic [3:0] d,
                               input logic mStb, input logic tipo,
                               input logic [63:0] bal, input logic [31:0] amt,
                               input logic unlock);
    tarjeta_recibida = card;
    digito_stb       = dStb;
    digito           = d;
    monto_stb        = mStb;
    tipo_trans       = tipo;
    balance_inicial  = bal;
    monto            = amt;
    desbloqueo       = unlock;
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycle(input logic card);
    applyStimulus(card, 1'b0, 4'd0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0);
  endtask

  task automatic digitCycle(input logic card, input logic [3:0] d);
    applyStimulus(card, 1'b1, d, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0);
  endtask

  // Four digit strobes (LSB slot first) plus the compare cycle.
  task automatic enterPin(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      digitCycle(1'b1, code[i*4 +: 4]);
    end
    idleCycle(1'b1);
  endtask

  task automatic transact(input logic tipo, input logic [63:0] bal, input logic [31:0] amt);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, tipo, bal, amt, 1'b0);
  endtask

  initial begin
    pin   = 16'h4321;
    reset = 1'b1;
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkFlags("resetFlags", F_NONE);
    checkOutput("resetBalance", balance_out, 64'd0);
    reset = 1'b0;

    // Deposit 250 onto 1000.
    idleCycle(1'b1);
    enterPin(16'h4321);
    checkFlags("goodPinQuiet", F_NONE);
    transact(TIPO_DEPOSITO, 64'd1000, 32'd250);
    checkFlags("depositPulse", F_UPD);
    checkOutput("depositBalance", balance_out, 64'd1250);
    idleCycle(1'b0);
    checkFlags("depositPulseEnds", F_NONE);
    checkOutput("depositHeld", balance_out, 64'd1250);

    // Withdraw 300 from 1000.
    idleCycle(1'b1);
    enterPin(16'h4321);
    transact(TIPO_RETIRO, 64'd1000, 32'd300);
    checkFlags("withdrawPulse", F_CASH);
    checkOutput("withdrawBalance", balance_out, 64'd700);
    idleCycle(1'b0);

    // Withdraw 1001 from 1000: refused, balance held.
    idleCycle(1'b1);
    enterPin(16'h4321);
    transact(TIPO_RETIRO, 64'd1000, 32'd1001);
    checkFlags("noFundsPulse", F_NOFND);
    checkOutput("noFundsHeld", balance_out, 64'd700);
    idleCycle(1'b0);

    // Withdraw exactly the whole balance.
    idleCycle(1'b1);
    enterPin(16'h4321);
    transact(TIPO_RETIRO, 64'd1000, 32'd1000);
    checkFlags("exactWithdraw", F_CASH);
    checkOutput("exactWithdrawBal", balance_out, 64'd0);
    idleCycle(1'b0);

    // Saturating deposit.
    idleCycle(1'b1);
    enterPin(16'h4321);
    transact(TIPO_DEPOSITO, 64'hFFFF_FFFF_FFFF_FFF0, 32'hFFFF_FFFF);
    checkFlags("saturatePulse", F_UPD);
    checkOutput("saturateBalance", balance_out, 64'hFFFF_FFFF_FFFF_FFFF);
    idleCycle(1'b0);

    // Timeout after two digits; last strobe resets the idle count.
    idleCycle(1'b1);
    digitCycle(1'b1, 4'd1);
    digitCycle(1'b1, 4'd2);
    repeat (1023) idleCycle(1'b1);
    checkFlags("noEarlyTimeout", F_NONE);
    idleCycle(1'b1);
    checkFlags("timeoutPulse", F_TOUT);
    idleCycle(1'b1);
    enterPin(16'h4321);
    checkFlags("afterTimeoutPin", F_NONE);
    transact(TIPO_DEPOSITO, 64'd10, 32'd5);
    checkOutput("afterTimeoutBal", balance_out, 64'd15);
    idleCycle(1'b0);

    // Card pulled after three digits, beating a simultaneous strobe.
    idleCycle(1'b1);
    digitCycle(1'b1, 4'd1);
    digitCycle(1'b1, 4'd2);
    digitCycle(1'b1, 4'd3);
    digitCycle(1'b0, 4'd4);
    checkFlags("cardPulledQuiet", F_NONE);
    idleCycle(1'b1);
    enterPin(16'h4321);
    checkFlags("afterPullPin", F_NONE);
    transact(TIPO_DEPOSITO, 64'd100, 32'd1);
    checkOutput("afterPullBal", balance_out, 64'd101);
    idleCycle(1'b0);

    // Attempts persist across card removal; a correct PIN clears the warning.
    idleCycle(1'b1);
    enterPin(16'h1111);
    checkFlags("persistFirst", F_BAD);
    idleCycle(1'b0);
    checkFlags("persistPulled", F_NONE);
    idleCycle(1'b1);
    enterPin(16'h1111);
    checkFlags("persistWarn", F_WARN);
    enterPin(16'h4321);
    checkFlags("warnCleared", F_NONE);
    idleCycle(1'b0);
    checkFlags("waitAmtPulled", F_NONE);

    // Three wrong attempts lock; strobes ignored while locked; unlock.
    idleCycle(1'b1);
    enterPin(16'h1111);
    checkFlags("wrong1", F_BAD);
    enterPin(16'h1111);
    checkFlags("wrong2", F_WARN);
    enterPin(16'h1111);
    checkFlags("wrong3Lock", F_LOCK);
    enterPin(16'h4321);
    checkFlags("lockedDigits", F_LOCKD);
    transact(TIPO_DEPOSITO, 64'd1, 32'd1);
    checkFlags("lockedMonto", F_LOCKD);
    checkOutput("lockedBalance", balance_out, 64'd101);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b1);
    checkFlags("unlocked", F_NONE);
    idleCycle(1'b1);
    enterPin(16'h4321);
    checkFlags("afterUnlockPin", F_NONE);
    transact(TIPO_DEPOSITO, 64'd20, 32'd2);
    checkOutput("afterUnlockBal", balance_out, 64'd22);
    idleCycle(1'b0);

    // Desbloqueo outside LOCKED has no effect on a warning in progress.
    idleCycle(1'b1);
    enterPin(16'h1111);
    enterPin(16'h1111);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b1);
    checkFlags("unlockIgnored", F_BADW);
    enterPin(16'h1111);
    checkFlags("relock", F_LOCK);

    // Reset while locked clears everything.
    reset = 1'b1;
    idleCycle(1'b0);
    checkFlags("resetInLock", F_NONE);
    checkOutput("resetInLockBal", balance_out, 64'd0);
    reset = 1'b0;
    idleCycle(1'b1);
    enterPin(16'h4321);
    checkFlags("afterResetPin", F_NONE);
    transact(TIPO_DEPOSITO, 64'd0, 32'd7);
    checkFlags("afterResetPulse", F_UPD);
    checkOutput("afterResetBal", balance_out, 64'd7);
    idleCycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule : tb_atm_controller
